// File: rtl/conv_window_feeder_pkg.sv
// Shared constants and window packing helpers for the convolution window feeder.
// The 3x3 window is packed row-major, element k = 3r+c, r=0 being the oldest row.
package conv_window_feeder_pkg;

    localparam int PIX_W     = 8;
    localparam int NWIN      = 9;
    localparam int W_W       = 4;
    localparam int EXPB_W    = 5;
    localparam int IMG_BUS_W = NWIN * PIX_W;
    localparam int WGT_BUS_W = NWIN * W_W;

    typedef logic [PIX_W-1:0] pix_t;

    function automatic int win_idx(input int r, input int c);
        return 3 * r + c;
    endfunction

endpackage

// File: rtl/conv_window_feeder_line_buffer.sv
// Two stacked row buffers: row1 holds the previous row, row0 the one before it.
// Combinational read at col; a write pushes row1[col] down into row0[col].
module conv_window_feeder_line_buffer
    import conv_window_feeder_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int CW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [CW-1:0] col,
    input  pix_t          din,
    output pix_t          rd_row0,
    output pix_t          rd_row1
);

    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    logic [AW-1:0] addr;
    pix_t          row0 [IMG_W];
    pix_t          row1 [IMG_W];

    assign addr    = col[AW-1:0];
    assign rd_row0 = row0[addr];
    assign rd_row1 = row1[addr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < IMG_W; i++) begin
                row0[i] <= '0;
                row1[i] <= '0;
            end
        end else if (we) begin
            row0[addr] <= row1[addr];
            row1[addr] <= din;
        end
    end

endmodule

// File: rtl/conv_window_feeder.sv
// Raster pixel stream to 3x3 convolution windows for the SD4 MAC, with the
// weight set and exponent bias held stable beside each window.
module conv_window_feeder #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int PIX_W = 8,
    parameter int CW    = 5
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [PIX_W-1:0]                             pix_in,
    input  logic                                         pix_valid,
    input  logic [conv_window_feeder_pkg::WGT_BUS_W-1:0] weight_in,
    input  logic [conv_window_feeder_pkg::EXPB_W-1:0]    exp_bias_in,
    input  logic                                         weight_load,
    output logic [conv_window_feeder_pkg::IMG_BUS_W-1:0] image,
    output logic [conv_window_feeder_pkg::WGT_BUS_W-1:0] weight,
    output logic [conv_window_feeder_pkg::EXPB_W-1:0]    exp_bias,
    output logic                                         win_valid,
    output logic                                         frame_done,
    output logic                                         busy
);
    import conv_window_feeder_pkg::*;

    logic [CW-1:0]        row_p0;
    logic [CW-1:0]        col_p0;
    logic [PIX_W-1:0]     win_p0  [3][3];
    logic [PIX_W-1:0]     win_nxt [3][3];
    logic [PIX_W-1:0]     lb0_rd;
    logic [PIX_W-1:0]     lb1_rd;
    logic [IMG_BUS_W-1:0] image_nxt;
    logic                 at_last_col;
    logic                 at_last_row;
    logic                 win_ok;

    conv_window_feeder_line_buffer #(
        .IMG_W (IMG_W),
        .CW    (CW)
    ) u_line_buffer (
        .clk     (clk),
        .rst     (rst),
        .we      (pix_valid),
        .col     (col_p0),
        .din     (pix_in),
        .rd_row0 (lb0_rd),
        .rd_row1 (lb1_rd)
    );

    assign at_last_col = (col_p0 == CW'(IMG_W - 1));
    assign at_last_row = (row_p0 == CW'(IMG_H - 1));
    // A window needs two full rows above and two columns to the left in this row.
    assign win_ok      = (row_p0 >= CW'(2)) && (col_p0 >= CW'(2));
    assign busy        = (row_p0 != '0) || (col_p0 != '0);

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win_nxt[r][0] = win_p0[r][1];
            win_nxt[r][1] = win_p0[r][2];
        end
        win_nxt[0][2] = lb0_rd;
        win_nxt[1][2] = lb1_rd;
        win_nxt[2][2] = pix_in;
        image_nxt = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                image_nxt[win_idx(r, c)*PIX_W +: PIX_W] = win_nxt[r][c];
            end
        end
    end

    // Stage p0 -> output: window shift, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_p0     <= '0;
            col_p0     <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            image      <= '0;
            weight     <= '0;
            exp_bias   <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_p0[r][c] <= '0;
                end
            end
        end else begin
            win_valid  <= pix_valid && win_ok;
            frame_done <= pix_valid && win_ok && at_last_row && at_last_col;
            // Weights may only change between frames so a frame never mixes sets.
            if (weight_load && !busy) begin
                weight   <= weight_in;
                exp_bias <= exp_bias_in;
            end
            if (pix_valid) begin
                win_p0 <= win_nxt;
                if (win_ok) begin
                    image <= image_nxt;
                end
                if (at_last_col) begin
                    col_p0 <= '0;
                    row_p0 <= at_last_row ? '0 : row_p0 + CW'(1);
                end else begin
                    col_p0 <= col_p0 + CW'(1);
                end
            end
        end
    end

endmodule

// File: doc/conv_window_feeder.md
Name: conv_window_feeder

Overview:
- Upstream neighbour of the 5-stage SD4 MAC pipeline.
- Turns a raster-order 8-bit pixel stream into 3x3 convolution windows, packed as the 72-bit image bus the MAC consumes.
- Holds the 36-bit weight set and the 5-bit exp_bias stable beside each window.
- Contains two line buffers, a 3x3 window register, row/column counters, and frame bookkeeping.

Parameters:
IMG_W, 28, pixels per row (>=3)
IMG_H, 28, rows per frame (>=3)
PIX_W, 8, pixel width; fixed at 8 so that 9*PIX_W = 72
CW, 5, counter width; must satisfy 2^CW >= max(IMG_W, IMG_H)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
pix_in  in  8  input pixel, raster order, row 0 first
pix_valid  in  1  pix_in valid this cycle; no backpressure
weight_in  in  36  nine 4-bit weights, k-th at [4k+3:4k]
exp_bias_in  in  5  exponent bias for the weight set
weight_load  in  1  load pulse for weight_in/exp_bias_in
image  out  72  3x3 window; element k = 3r+c at [8k+7:8k]; r=0 is the oldest row, c=0 the leftmost column
weight  out  36  registered weight set
exp_bias  out  5  registered exponent bias
win_valid  out  1  image holds a new complete window this cycle
frame_done  out  1  one-cycle pulse with the final window of a frame
busy  out  1  frame in progress (row != 0 or col != 0)

Behaviour:
- Reset (rst=0, asynchronous): the following are all 0: image, weight, exp_bias, win_valid, frame_done, busy, the counters, both line buffers and the window register.
- Accepting a pixel (pix_valid=1, at (row, col)):
  - Pixel is written into line buffer 1 at col.
  - The old line buffer 1 entry moves to line buffer 0 at col.
  - The window register shifts left one column. The new right column is {lb0[col], lb1[col], pix_in} for r = 0, 1, 2.
- Counters: col increments per accepted pixel. At IMG_W-1, col wraps to 0 and row increments. At (IMG_H-1, IMG_W-1), both wrap to 0.
- Window output:
  - win_valid is registered and asserts the cycle after accepting a pixel with row>=2 and col>=2.
  - image updates in that same registered cycle.
  - Windows never span a row boundary: the col>=2 gate suppresses them, though shifting continues.
- Idle input: pix_valid=0 means counters, buffers and image hold, and win_valid=0 next cycle.
- Back-to-back pixels give back-to-back windows. There are (IMG_W-2)*(IMG_H-2) windows per frame.
- frame_done: asserts together with the win_valid for pixel (IMG_H-1, IMG_W-1). A following frame may start on the very next cycle with no gap.
- Latency: accepted pixel to image/win_valid is 1 cycle. The MAC result follows at its own fixed pipeline depth.
- busy: combinational from the counters.
- Weight load:
  - weight_load=1 with busy=0 registers weight_in and exp_bias_in on that edge; outputs are visible next cycle.
  - weight_load while busy=1 is ignored.
  - weight_load coinciding with the first pixel of a frame (busy=0) is accepted, so the whole frame uses the new weights.
- Reset mid-frame: everything clears and the next accepted pixel is treated as (0,0).
- image holds its last window while win_valid=0. Downstream must qualify with win_valid.

Decomposition:
- Shared package holds:
  - window packing index function k = 3r+c;
  - constants PIX_W=8, NWIN=9, W_W=4, EXPB_W=5;
  - the bus widths 72 and 36.
- One natural sub-module, line_buffer: a dual-row single-write RAM/shift array of IMG_W x 8, with combinational read at col and registered write. It is instantiated once and carries both rows.

Test Plan:
- Window ordering and first window: IMG_W=IMG_H=4, pixels 0..15 back-to-back. Require:
  - win_valid on 4 cycles total;
  - first window (after pixel 10): image[7:0]=0, [15:8]=1, [23:16]=2, [31:24]=4, [39:32]=5, [47:40]=6, [55:48]=8, [63:56]=9, [71:64]=10;
  - last window elements 5,6,7,9,10,11,13,14,15, with frame_done=1.
- Input bubbles: same 4x4 frame with pix_valid=0 every other cycle. Require identical window contents, win_valid only after accepted pixels, and image stable through bubbles.
- Weight load gating:
  - weight_load with weight_in=36'h123456789 and exp_bias_in=5'd15 while idle: outputs update next cycle.
  - A second load with weight_in=36'hFFFFFFFFF mid-frame: outputs keep 36'h123456789.
- Back-to-back frames: two consecutive 28x28 frames with no gap. Require 676 win_valid per frame, frame_done exactly twice, and the second frame's first window containing only second-frame pixels.
- Reset mid-frame: drop rst at row 1, col 5. Require all outputs 0 immediately (asynchronous). After release, a fresh 4x4 frame reproduces the first scenario exactly.
- Row boundary: 5x4 frame. Require no win_valid for col 0/1 pixels of rows >=2, and 3 windows per valid row.
